// File: rtl/mem_rw0_driver.sv
// Request-stream initiator for a single-port RW0 SRAM macro: optional post-reset zero-fill,
// credit-gated request acceptance and an in-order read-response FIFO.
module mem_rw0_driver #(
   parameter int unsigned ADDR_W        = 13,
   parameter int unsigned DATA_W        = 64,
   parameter int unsigned MASK_W        = DATA_W / 8,
   parameter int unsigned RESP_DEPTH    = 3,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_wmask,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              init_done,
   output logic              RW0_clk,
   output logic              RW0_en,
   output logic              RW0_wmode,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic [DATA_W-1:0] RW0_wdata,
   output logic [MASK_W-1:0] RW0_wmask,
   input  logic [DATA_W-1:0] RW0_rdata
);

   localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(RESP_DEPTH + 1);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RESP_DEPTH - 1);
   localparam logic [OCC_W:0]    CREDITS  = (OCC_W + 1)'(RESP_DEPTH);
   localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
   localparam state_t RST_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

   state_t             state_r, state_nxt_s;
   logic               sweep_go_r;
   logic [ADDR_W-1:0]  init_cnt_r;
   logic               init_done_r;
   logic               ready_r, ready_nxt_s;
   logic               inflight_r, inflight_nxt_s;
   logic [OCC_W-1:0]   occ_r, occ_nxt_s;
   logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
   logic [DATA_W-1:0]  fifo_mem_r [RESP_DEPTH];
   logic               rd_acc_s, push_s, pop_s;

   assign RW0_clk    = clock;
   assign req_ready  = ready_r;
   assign init_done  = init_done_r;
   assign resp_valid = (occ_r != {OCC_W{1'b0}});
   assign resp_rdata = fifo_mem_r[rd_ptr_r];

   // Next-state: the sweep ends on the cycle that writes the last address.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (sweep_go_r && (init_cnt_r == CNT_LAST)) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_RUN:  state_nxt_s = ST_RUN;
         default: state_nxt_s = RST_STATE;
      endcase
   end

   // Macro port drive; sweep_go_r keeps the port idle while reset is held.
   always_comb begin
      RW0_en    = 1'b0;
      RW0_wmode = 1'b0;
      RW0_addr  = {ADDR_W{1'b0}};
      RW0_wdata = {DATA_W{1'b0}};
      RW0_wmask = {MASK_W{1'b0}};
      case (state_r)
         ST_INIT: begin
            RW0_en    = sweep_go_r;
            RW0_wmode = 1'b1;
            RW0_addr  = init_cnt_r;
            RW0_wdata = {DATA_W{1'b0}};
            RW0_wmask = {MASK_W{1'b1}};
         end
         ST_RUN: begin
            RW0_en    = req_valid & ready_r;
            RW0_wmode = req_write;
            RW0_addr  = req_addr;
            RW0_wdata = req_wdata;
            RW0_wmask = req_wmask;
         end
         default: RW0_en = 1'b0;
      endcase
   end

   // Credit bookkeeping: occupancy plus the one possible in-flight read gate acceptance.
   always_comb begin
      rd_acc_s       = (state_r == ST_RUN) & RW0_en & ~req_write;
      push_s         = inflight_r;
      pop_s          = resp_valid & resp_ready;
      inflight_nxt_s = rd_acc_s;
      case ({push_s, pop_s})
         2'b10:   occ_nxt_s = occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
         2'b01:   occ_nxt_s = occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
         default: occ_nxt_s = occ_r;
      endcase
      if (state_nxt_s == ST_RUN) begin
         ready_nxt_s = (({1'b0, occ_nxt_s} + {{OCC_W{1'b0}}, inflight_nxt_s}) < CREDITS);
      end else begin
         ready_nxt_s = 1'b0;
      end
   end

   // Control state, sweep counter and sticky init flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= RST_STATE;
         sweep_go_r  <= 1'b0;
         init_cnt_r  <= {ADDR_W{1'b0}};
         init_done_r <= !INIT_ON_RESET;
         ready_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         sweep_go_r <= 1'b1;
         ready_r    <= ready_nxt_s;
         if ((state_r == ST_INIT) && sweep_go_r) begin
            init_cnt_r <= init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         end
         if (state_nxt_s == ST_RUN) begin
            init_done_r <= 1'b1;
         end
      end
   end

   // Response FIFO pointers, occupancy and in-flight flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inflight_r <= 1'b0;
         occ_r      <= {OCC_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
      end else begin
         inflight_r <= inflight_nxt_s;
         occ_r      <= occ_nxt_s;
         if (push_s) begin
            wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // FIFO storage captures macro read data the cycle after the read edge.
   always_ff @(posedge clock) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= RW0_rdata;
      end
   end

endmodule

// File: tb/tb_mem_rw0_driver.sv
// Scoreboard bench for mem_rw0_driver: behavioural memory model predicts read data,
// a monitor pops expectations whenever a response is consumed.
module tb_mem_rw0_driver;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 64;
   localparam int MASK_W = 8;
   localparam int WORDS  = 16;

   logic              clock;
   logic              reset_n;
   logic              req_valid, req_ready, req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [MASK_W-1:0] req_wmask;
   logic              resp_valid, resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              init_done;
   logic              RW0_clk, RW0_en, RW0_wmode;
   logic [ADDR_W-1:0] RW0_addr;
   logic [DATA_W-1:0] RW0_wdata;
   logic [MASK_W-1:0] RW0_wmask;
   logic [DATA_W-1:0] RW0_rdata;

   int n_cmp = 0;
   int n_err = 0;

   logic [DATA_W-1:0] macro_mem [WORDS];
   logic [DATA_W-1:0] ref_mem   [WORDS];
   logic [DATA_W-1:0] exp_q [$];

   mem_rw0_driver #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
      .RESP_DEPTH(3), .INIT_ON_RESET(1'b1)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .init_done(init_done), .RW0_clk(RW0_clk), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
      .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DATA_W-1:0] expand(input logic [MASK_W-1:0] m);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < MASK_W; i++) r[i*8 +: 8] = {8{m[i]}};
      return r;
   endfunction

   // SRAM macro stand-in with 1-cycle read latency.
   always @(posedge RW0_clk) begin
      if (RW0_en) begin
         if (RW0_wmode)
            macro_mem[RW0_addr] <= (macro_mem[RW0_addr] & ~expand(RW0_wmask)) | (RW0_wdata & expand(RW0_wmask));
         else
            RW0_rdata <= macro_mem[RW0_addr];
      end
   end

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Response monitor: every consumed response must match the oldest expectation.
   always @(negedge clock) begin
      if (reset_n && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: got %h with no outstanding read", resp_rdata);
         end else begin
            check("resp_data", resp_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic model_accept(input logic w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
      if (w) ref_mem[a] = (ref_mem[a] & ~expand(m)) | (d & expand(m));
      else   exp_q.push_back(ref_mem[a]);
   endtask

   task automatic drive_cycle(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m,
                              output logic acc, output logic rv);
      req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
      @(negedge clock);
      acc = v && req_ready;
      rv  = resp_valid;
      if (acc) model_accept(w, a, d, m);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
      logic acc, rv;
      int   n;
      acc = 1'b0; n = 0;
      while (!acc && n < 20) begin
         drive_cycle(1'b1, w, a, d, m, acc, rv);
         n++;
      end
      if (!acc) begin
         n_cmp++; n_err++;
         $display("FAIL issue_timeout: got no accept expected accept for addr %0d", a);
      end
   endtask

   task automatic read_lat(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] want);
      resp_ready = 1'b1;
      issue(1'b0, a, 64'h0, 8'h00);
      @(negedge clock);
      check({name, "_lat1_valid"}, 64'(resp_valid), 64'h0);
      @(posedge clock); #1;
      @(negedge clock);
      check({name, "_lat2_valid"}, 64'(resp_valid), 64'h1);
      check({name, "_lat2_data"}, resp_rdata, want);
      @(posedge clock); #1;
   endtask

   task automatic drain();
      int n;
      resp_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'h0);
      @(negedge clock);
      check("drain_no_valid", 64'(resp_valid), 64'h0);
      @(posedge clock); #1;
   endtask

   task automatic reset_and_sweep();
      int nwr, k;
      bit done;
      reset_n = 1'b0;
      #2;
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_resp_valid", 64'(resp_valid), 64'h0);
      check("rst_init_done", 64'(init_done), 64'h0);
      check("rst_rw0_en", 64'(RW0_en), 64'h0);
      req_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < WORDS; i++) ref_mem[i] = 64'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      nwr = 0; k = 0; done = 1'b0;
      while (!done && k < 40) begin
         @(negedge clock);
         k++;
         if (init_done) begin
            done = 1'b1;
         end else if (RW0_en) begin
            check("sweep_addr", 64'(RW0_addr), 64'(nwr));
            check("sweep_wmode", 64'(RW0_wmode), 64'h1);
            check("sweep_wdata", RW0_wdata, 64'h0);
            check("sweep_wmask", 64'(RW0_wmask), 64'hFF);
            nwr++;
         end
      end
      check("init_done_seen", 64'(done), 64'h1);
      check("sweep_writes", 64'(nwr), 64'd16);
      check("init_cycle", 64'(k), 64'd17);
      check("ready_after_init", 64'(req_ready), 64'h1);
      @(posedge clock); #1;
   endtask

   initial begin
      logic acc, rv;
      logic [12:0] rv_vec;
      logic [12:0] rv_want;
      logic [DATA_W-1:0] v1;
      int    nacc;
      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
      for (int i = 0; i < WORDS; i++) macro_mem[i] = {$urandom, $urandom};
      RW0_rdata = {$urandom, $urandom};
      #1;

      reset_and_sweep();
      read_lat("rd5", 4'd5, 64'h0);

      // masked write then immediate read
      drive_cycle(1'b1, 1'b1, 4'd3, 64'h1122334455667788, 8'h0F, acc, rv);
      check("mw_accept", 64'(acc), 64'h1);
      read_lat("mw", 4'd3, 64'h0000000055667788);

      // backpressure
      for (int a = 1; a <= 4; a++) issue(1'b1, 4'(a), {$urandom, $urandom}, 8'hFF);
      drain();
      resp_ready = 1'b0;
      for (int a = 1; a <= 3; a++) begin
         drive_cycle(1'b1, 1'b0, 4'(a), 64'h0, 8'h00, acc, rv);
         check("bp_accept", 64'(acc), 64'h1);
      end
      nacc = 0;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 1'b0, 4'd4, 64'h0, 8'h00, acc, rv);
         if (acc) nacc++;
      end
      check("bp_held_accepts", 64'(nacc), 64'h0);
      v1 = ref_mem[1];
      @(negedge clock);
      check("bp_ready_low", 64'(req_ready), 64'h0);
      check("bp_head_stable", resp_rdata, v1);
      @(posedge clock); #1;
      @(negedge clock);
      check("bp_head_stable2", resp_rdata, v1);
      @(posedge clock); #1;
      resp_ready = 1'b1;
      issue(1'b0, 4'd4, 64'h0, 8'h00);
      drain();

      // throughput: 8 back-to-back reads
      resp_ready = 1'b1;
      for (int t = 0; t < 13; t++) begin
         drive_cycle(t < 8, 1'b0, 4'($urandom_range(0, 15)), 64'h0, 8'h00, acc, rv);
         if (t < 8) check("tp_accept", 64'(acc), 64'h1);
         rv_vec[t]  = rv;
         rv_want[t] = (t >= 2) && (t < 10);
      end
      check("tp_valid_pattern", 64'(rv_vec), 64'(rv_want));
      drain();

      // randomized mixed traffic with random response backpressure
      for (int i = 0; i < 300; i++) begin
         resp_ready = ($urandom_range(0, 3) != 0);
         drive_cycle($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                     4'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom), acc, rv);
      end
      drain();

      // reset with two queued responses and one read in flight
      resp_ready = 1'b0;
      for (int a = 0; a < 3; a++) begin
         drive_cycle(1'b1, 1'b0, 4'(a + 8), 64'h0, 8'h00, acc, rv);
         check("pre_reset_accept", 64'(acc), 64'h1);
      end
      check("pre_reset_valid", 64'(resp_valid), 64'h1);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7;
      reset_and_sweep();
      resp_ready = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      drain();
      read_lat("post_rst", 4'd9, 64'h0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_rw0_driver.md
Name: mem_rw0_driver

Overview:
- Initiator for a single-port RW0 SRAM macro port: addr, en, wmode, wdata, wmask, rdata, with 1-cycle read latency.
- Converts a valid/ready request stream into RW0 port cycles and captures read data into an in-order response FIFO with valid/ready backpressure.
- After reset it optionally zero-fills the whole macro before accepting traffic.
- Sits between a cache/LSU-side requester and a mem_* macro instance.

Parameters:
- ADDR_W, 13, RW0 address width; the macro depth is 2^ADDR_W.
- DATA_W, 64, data width.
- MASK_W, DATA_W/8, byte-mask width; 1 bit per 8 data bits.
- RESP_DEPTH, 3, response FIFO entries. Must be >= 1; >= 3 is required for 1 read/cycle.
- INIT_ON_RESET, 1, 1 = zero-fill the macro after reset; 0 = skip.

Ports:
- clock  in  1  sole clock; also forwarded to the macro.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid & ready at a clock edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_wmask  in  MASK_W  byte write enables.
- resp_valid  out  1  read response available.
- resp_ready  in  1  response consumed when valid & ready.
- resp_rdata  out  DATA_W  read data, returned in request order.
- init_done  out  1  high once the zero-fill is complete and sticky until reset.
- RW0_clk  out  1  equal to clock.
- RW0_en, RW0_wmode  out  1 each  macro enable and write-mode.
- RW0_addr  out  ADDR_W  macro address.
- RW0_wdata  out  DATA_W  macro write data.
- RW0_wmask  out  MASK_W  macro byte mask.
- RW0_rdata  in  DATA_W  macro read data, valid the cycle after a read edge.

Behaviour:
- Reset (async, reset_n=0) values:
  - req_ready=0, resp_valid=0, init_done=0, RW0_en=0.
  - FIFO empty, inflight=0, init counter=0, state=INIT.
  - If INIT_ON_RESET=0, the state is RUN with init_done=1.
- State INIT:
  - Each cycle drive RW0_en=1, RW0_wmode=1, RW0_addr=cnt, RW0_wdata=0, RW0_wmask=all ones; then cnt++.
  - At the edge where cnt=2^ADDR_W-1 go to RUN and set init_done=1. The sweep is exactly 2^ADDR_W cycles.
  - req_ready=0 throughout INIT.
- State RUN:
  - req_ready = (occ + inflight < RESP_DEPTH). Ready is registered-state only; it never depends on req_valid, req_write or resp_ready.
  - RW0_en = req_valid & req_ready, combinationally.
  - RW0_wmode, RW0_addr, RW0_wdata and RW0_wmask pass through from req_write, req_addr, req_wdata and req_wmask.
- Write:
  - The macro commits at the accept edge. No response is generated.
  - A read accepted on the next cycle to the same address returns the new data.
- Read:
  - At the accept edge, set inflight=1.
  - In the following cycle, push RW0_rdata into the FIFO and clear inflight, unless a new read is accepted in that same cycle, in which case inflight stays 1.
  - resp_valid rises 2 cycles after the accept edge.
- Throughput: with resp_ready held high and RESP_DEPTH>=3, 1 request is accepted per cycle indefinitely.
- Response FIFO:
  - resp_valid = ~empty; resp_rdata = head entry.
  - A push and a pop in the same cycle are both legal; occupancy is unchanged and order is preserved.
  - The FIFO never overflows, because credits (occ + inflight) gate req_ready.
- Response stability: while resp_valid=1 and resp_ready=0, resp_rdata is held stable.
- Reset mid-operation:
  - All in-flight and queued responses are discarded.
  - RW0_en drops immediately.
  - The zero-fill restarts from address 0.
- RUN is terminal until the next reset.

Test Plan:
- Init sweep: ADDR_W=4, INIT_ON_RESET=1, release reset → exactly 16 write cycles on addresses 0..15 with wdata=0 and wmask=0xFF; init_done=1 and req_ready=1 on cycle 17; a read of address 5 returns 0x0.
- Masked write: write address 3 with 0x1122334455667788 and mask 0x0F, then read address 3 the next cycle → resp_rdata=0x0000000055667788, 2 cycles after the read accept.
- Backpressure: resp_ready=0, req_valid held with reads to addresses 1, 2, 3, 4 → 3 accepted, req_ready=0; raise resp_ready → responses come back in order 1, 2, 3, then the 4th read is accepted and returned.
- Throughput: resp_ready=1, 8 back-to-back reads → 8 consecutive accepts and 8 consecutive resp_valid cycles, first response 2 cycles after the first accept.
- Reset mid-operation: assert reset_n=0 with 2 responses queued and 1 in flight → resp_valid=0 and RW0_en=0 asynchronously; after release the sweep restarts at address 0 and no stale responses appear.
- Simultaneous push and pop: with occ=1 and resp_ready=1, sustain reads → occupancy stays 1 and data order matches the issue order.
